// File: rtl/kf_au_arbiter.sv
// ============================================================================
// Module      : kf_au_arbiter
// Description : Two-requester arbiter/sequencer for the shared Kalman AU.
//               Optional macro KF_AU_ARB_FIXED_PRIO_EN: ties go to requester 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kf_au_arbiter #(
  parameter int W     = 24,
  parameter int TMO_W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [1:0]   op0,
  input  logic [1:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy,
  output logic         au_start,
  output logic [1:0]   au_op,
  output logic [W-1:0] au_a,
  output logic [W-1:0] au_b,
  input  logic         au_done,
  input  logic [W-1:0] au_result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LIMIT = '1;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic [1:0]       au_op_q, au_op_d;
  logic [W-1:0]     au_a_q, au_a_d;
  logic [W-1:0]     au_b_q, au_b_d;
  logic [W-1:0]     result_q, result_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             au_start_q, au_start_d;
  logic             tie_gnt;
  logic             pick;

`ifdef KF_AU_ARB_FIXED_PRIO_EN
  assign tie_gnt = 1'b0;
`else
  assign tie_gnt = ~last_q;
`endif

  assign pick = (req0 && req1) ? tie_gnt : req1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    au_op_d    = au_op_q;
    au_a_d     = au_a_q;
    au_b_d     = au_b_q;
    result_d   = result_q;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    err_d      = 1'b0;
    au_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d      = pick;
          last_d     = pick;
          au_op_d    = pick ? op1 : op0;
          au_a_d     = pick ? a1  : a0;
          au_b_d     = pick ? b1  : b0;
          au_start_d = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion on the limit cycle takes precedence over the abort.
        if (au_done) begin
          result_d = au_result;
          done0_d  = ~gnt_q;
          done1_d  = gnt_q;
          state_d  = S_DONE;
        end else if (cnt_q == TMO_LIMIT) begin
          result_d = '0;
          err_d    = 1'b1;
          done0_d  = ~gnt_q;
          done1_d  = gnt_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      au_op_q    <= '0;
      au_a_q     <= '0;
      au_b_q     <= '0;
      result_q   <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      au_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      au_op_q    <= au_op_d;
      au_a_q     <= au_a_d;
      au_b_q     <= au_b_d;
      result_q   <= result_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      au_start_q <= au_start_d;
    end
  end

  assign done0    = done0_q;
  assign done1    = done1_q;
  assign result   = result_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign au_start = au_start_q;
  assign au_op    = au_op_q;
  assign au_a     = au_a_q;
  assign au_b     = au_b_q;

endmodule

`default_nettype wire

// File: tb/tb_kf_au_arbiter.sv
// ============================================================================
// Module      : tb_kf_au_arbiter
// Description : Directed self-checking bench for kf_au_arbiter with a simple
//               latency-programmable AU model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kf_au_arbiter;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [1:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         done0, done1, err, busy, au_start;
  logic [W-1:0] result, au_a, au_b;
  logic [1:0]   au_op;
  logic         au_done = 1'b0;
  logic [W-1:0] au_result = '0;

  int n_cmp = 0;
  int n_err = 0;
  int lat_m = -1;
  int cnt_m = 0;

  kf_au_arbiter #(.W(W), .TMO_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
    .au_start(au_start), .au_op(au_op), .au_a(au_a), .au_b(au_b),
    .au_done(au_done), .au_result(au_result)
  );

  always #5 clk = ~clk;

  // AU model: au_done is high during the cycle lat_m cycles after the start
  // cycle; lat_m <= 0 means the AU never answers.
  always @(negedge clk) begin
    if (au_start === 1'b1) begin
      au_done = 1'b0;
      cnt_m   = lat_m;
    end else if (cnt_m > 0) begin
      cnt_m = cnt_m - 1;
      if (cnt_m == 0) begin
        au_done   = 1'b1;
        au_result = au_a + au_b;
      end
    end else begin
      au_done = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({done0, done1, err, busy, au_start, au_op, au_a, au_b, result} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {done0, done1, err, busy, au_start, au_op, au_a, au_b, result});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp_g;
    logic ok;
    a0 = 24'h000111; b0 = '0; op0 = 2'b00;
    a1 = 24'h000222; b1 = '0; op1 = 2'b00;
    lat_m = 2;
    req0 = 1'b1; req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
`ifdef KF_AU_ARB_FIXED_PRIO_EN
      exp_g = (t == 3);
`else
      exp_g = (t % 2 == 1);
`endif
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        step();
        if (au_start === 1'b1) ok = 1'b1;
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL rr_start_timeout[%0d]: got no au_start want au_start", t);
      end else if (au_a !== (exp_g ? a1 : a0)) begin
        n_err++;
        $display("FAIL rr_au_a[%0d]: got %h want %h", t, au_a, exp_g ? a1 : a0);
      end
      ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        step();
        if (done0 === 1'b1 || done1 === 1'b1) ok = 1'b1;
      end
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL rr_done_timeout[%0d]: got no done want done", t);
      end else if ({done1, done0} !== (exp_g ? 2'b10 : 2'b01)) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got done1,done0=%b want %b", t,
                 {done1, done0}, exp_g ? 2'b10 : 2'b01);
      end
`ifdef KF_AU_ARB_FIXED_PRIO_EN
      if (t == 2) req0 = 1'b0;
`endif
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  task automatic test_single();
    a0 = 24'h004000; b0 = 24'h0000A3; op0 = 2'b00;
    lat_m = 3;
    req0 = 1'b1;
    step();
    n_cmp++;
    if ({au_start, busy} !== 2'b11) begin
      n_err++;
      $display("FAIL single_issue: got start,busy=%b want 11", {au_start, busy});
    end
    for (int k = 2; k <= 5; k++) begin
      step();
      n_cmp++;
      if ({done0, done1, err, au_start} !== ((k == 5) ? 4'b1000 : 4'b0000)) begin
        n_err++;
        $display("FAIL single_cycle%0d: got done0,done1,err,start=%b want %b", k,
                 {done0, done1, err, au_start}, (k == 5) ? 4'b1000 : 4'b0000);
      end
      if (k == 5) begin
        n_cmp++;
        if (result !== 24'h0040A3) begin
          n_err++;
          $display("FAIL single_result: got %h want 0040a3", result);
        end
        req0 = 1'b0;
      end
    end
    step();
    n_cmp++;
    if ({busy, done0} !== 2'b00) begin
      n_err++;
      $display("FAIL single_idle: got busy,done0=%b want 00", {busy, done0});
    end
  endtask

  task automatic test_operand_stability();
    logic seen;
    a0 = 24'h000123; b0 = 24'h000010; op0 = 2'b10;
    lat_m = 4;
    req0 = 1'b1;
    step();
    a0 = 24'h0ABCDE; b0 = 24'h055555; op0 = 2'b11;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      n_cmp++;
      if ({au_op, au_a, au_b} !== {2'b10, 24'h000123, 24'h000010}) begin
        n_err++;
        $display("FAIL stable_operands[%0d]: got op,a,b=%h,%h,%h want 2,000123,000010",
                 k, au_op, au_a, au_b);
      end
      if (done0 === 1'b1) seen = 1'b1;
      else step();
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL stable_done_timeout: got no done0 want done0");
    end else if (result !== 24'h000133) begin
      n_err++;
      $display("FAIL stable_result: got %h want 000133", result);
    end
    req0 = 1'b0;
    a0 = '0; b0 = '0; op0 = 2'b00;
    step();
  endtask

  task automatic test_watchdog(input int lat, input logic [1:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] exp_res, input logic exp_err);
    a1 = a; b1 = b; op1 = op;
    lat_m = lat;
    req1 = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      step();
      n_cmp++;
      if ({done1, done0, err} !== ((k == 66) ? {2'b10, exp_err} : 3'b000)) begin
        n_err++;
        $display("FAIL wdog_lat%0d_cycle%0d: got done1,done0,err=%b want %b", lat, k,
                 {done1, done0, err}, (k == 66) ? {2'b10, exp_err} : 3'b000);
      end
      if (k == 66) begin
        n_cmp++;
        if (result !== exp_res) begin
          n_err++;
          $display("FAIL wdog_lat%0d_result: got %h want %h", lat, result, exp_res);
        end
        req1 = 1'b0;
      end
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL wdog_lat%0d_idle: got busy=%b want 0", lat, busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic ok;
    a0 = 24'h000005; b0 = 24'h000007; op0 = 2'b10;
    lat_m = 10;
    req0 = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    req0  = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({done0, done1, err, busy, au_start, au_op, au_a, au_b, result} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got %h want 0",
               {done0, done1, err, busy, au_start, au_op, au_a, au_b, result});
    end
    for (int k = 0; k < 14; k++) begin
      step();
      n_cmp++;
      if ({done0, done1, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL midreset_late_done[%0d]: got done0,done1,busy=%b want 000",
                 k, {done0, done1, busy});
      end
    end
    a0 = 24'h000AAA; a1 = 24'h000BBB; b0 = '0; b1 = '0; op0 = 2'b00; op1 = 2'b00;
    lat_m = 2;
    req0 = 1'b1; req1 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      step();
      if (au_start === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL midreset_tie_timeout: got no au_start want au_start");
    end else if (au_a !== 24'h000AAA) begin
      n_err++;
      $display("FAIL midreset_tie_grant: got au_a=%h want 000aaa", au_a);
    end
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      step();
      if (done0 === 1'b1 || done1 === 1'b1) ok = 1'b1;
    end
    n_cmp++;
    if (!ok || {done1, done0} !== 2'b01) begin
      n_err++;
      $display("FAIL midreset_tie_done: got done1,done0=%b want 01", {done1, done0});
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_operand_stability();
    test_watchdog(-1, 2'b11, 24'h001000, 24'h000000, 24'h000000, 1'b1);
    test_watchdog(64, 2'b00, 24'h000100, 24'h000200, 24'h000300, 1'b0);
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion want completion");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
